// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the decode stage.
//   - opcode encodings (5-bit opcode field)
//   - bit positions inside the 12-bit control word
//   - ALU op codes that select the multicycle mult/div unit
//   - FSM state type and encodings for the decode-stage sequencer
package ctrl_pkg;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_J     = 5'b00001;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SETX  = 5'b10101;
   localparam logic [4:0] OP_BEX   = 5'b10110;

   // Control word bit positions, bit 11 down to bit 0.
   localparam int unsigned CTRL_BRNE   = 11;
   localparam int unsigned CTRL_BRLT   = 10;
   localparam int unsigned CTRL_JP     = 9;
   localparam int unsigned CTRL_JAL    = 8;
   localparam int unsigned CTRL_JR     = 7;
   localparam int unsigned CTRL_BEX    = 6;
   localparam int unsigned CTRL_SETX   = 5;
   localparam int unsigned CTRL_ALUINB = 4;
   localparam int unsigned CTRL_DMWE   = 3;
   localparam int unsigned CTRL_RWE    = 2;
   localparam int unsigned CTRL_RDST   = 1;
   localparam int unsigned CTRL_RWD    = 0;

   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE    = 1'b0;
   localparam state_t ST_MD_WAIT = 1'b1;

endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: purely combinational instruction decoder.
//   insn    in   INSN_W   instruction word
//   ctrl    out  CTRL_W   control word {BRNE..RWD}
//   aluop   out  5        ALU op (R-type only, else zero)
//   rd/rs/rt out REG_W    register specifiers following the opcode
//   imm     out  INSN_W   sign-extended low IMM_W bits
//   illegal out  1        opcode is undefined (ctrl forced to zero)
//   is_md   out  1        R-type mul/div needing the multicycle unit
module ctrl_decode_comb
   import ctrl_pkg::*;
#(
   parameter int unsigned INSN_W   = 32,
   parameter int unsigned OPCODE_W = 5,
   parameter int unsigned REG_W    = 5,
   parameter int unsigned IMM_W    = 17,
   parameter int unsigned CTRL_W   = 12
) (
   input  logic [INSN_W-1:0] insn,
   output logic [CTRL_W-1:0] ctrl,
   output logic [4:0]        aluop,
   output logic [REG_W-1:0]  rd,
   output logic [REG_W-1:0]  rs,
   output logic [REG_W-1:0]  rt,
   output logic [INSN_W-1:0] imm,
   output logic              illegal,
   output logic              is_md
);

   logic [OPCODE_W-1:0] opcode;
   logic                is_rtype;

   assign opcode   = insn[INSN_W-1 -: OPCODE_W];
   assign rd       = insn[INSN_W-OPCODE_W-1 -: REG_W];
   assign rs       = insn[INSN_W-OPCODE_W-REG_W-1 -: REG_W];
   assign rt       = insn[INSN_W-OPCODE_W-2*REG_W-1 -: REG_W];
   assign imm      = {{(INSN_W-IMM_W){insn[IMM_W-1]}}, insn[IMM_W-1:0]};
   assign is_rtype = (opcode == OP_RTYPE);
   assign aluop    = is_rtype ? insn[6:2] : 5'b00000;
   assign is_md    = is_rtype && ((insn[6:2] == ALU_MUL) || (insn[6:2] == ALU_DIV));

   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: ctrl[CTRL_RWE] = 1'b1;
         OP_ADDI: begin
            ctrl[CTRL_ALUINB] = 1'b1;
            ctrl[CTRL_RWE]    = 1'b1;
         end
         OP_SW: begin
            ctrl[CTRL_ALUINB] = 1'b1;
            ctrl[CTRL_DMWE]   = 1'b1;
            ctrl[CTRL_RDST]   = 1'b1;
         end
         OP_LW: begin
            ctrl[CTRL_ALUINB] = 1'b1;
            ctrl[CTRL_RWE]    = 1'b1;
            ctrl[CTRL_RWD]    = 1'b1;
         end
         OP_J: ctrl[CTRL_JP] = 1'b1;
         OP_JAL: begin
            ctrl[CTRL_JP]  = 1'b1;
            ctrl[CTRL_JAL] = 1'b1;
            ctrl[CTRL_RWE] = 1'b1;
         end
         OP_JR: begin
            ctrl[CTRL_JR]   = 1'b1;
            ctrl[CTRL_RDST] = 1'b1;
         end
         OP_BNE: begin
            ctrl[CTRL_BRNE] = 1'b1;
            ctrl[CTRL_RDST] = 1'b1;
         end
         OP_BLT: begin
            ctrl[CTRL_BRLT] = 1'b1;
            ctrl[CTRL_RDST] = 1'b1;
         end
         OP_SETX: begin
            ctrl[CTRL_SETX] = 1'b1;
            ctrl[CTRL_RWE]  = 1'b1;
         end
         OP_BEX: ctrl[CTRL_BEX] = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered, handshaked decode stage.
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_insn/in_valid/in_ready   fetch-side handshake
//   flush                   kills held/pending instruction, wins over all
//   out_ctrl/aluop/rd/rs/rt/imm/illegal  registered decode results
//   out_valid/out_ready     execute-side handshake
//   md_start/md_done        mult/div unit sequencing
// Build option: define DECODE_MULTDIV_EN to sequence mul/div through MD_WAIT;
// otherwise mul/div decode as ordinary single-cycle R-type and md_done is unused.
module ctrl_decode_stage
   import ctrl_pkg::*;
#(
   parameter int unsigned INSN_W   = 32,
   parameter int unsigned OPCODE_W = 5,
   parameter int unsigned REG_W    = 5,
   parameter int unsigned IMM_W    = 17,
   parameter int unsigned CTRL_W   = 12
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [INSN_W-1:0] in_insn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [4:0]        out_aluop,
   output logic [REG_W-1:0]  out_rd,
   output logic [REG_W-1:0]  out_rs,
   output logic [REG_W-1:0]  out_rt,
   output logic [INSN_W-1:0] out_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              md_start,
   input  logic              md_done,
   output logic              illegal
);

   logic [CTRL_W-1:0] dec_ctrl;
   logic [4:0]        dec_aluop;
   logic [REG_W-1:0]  dec_rd, dec_rs, dec_rt;
   logic [INSN_W-1:0] dec_imm;
   logic              dec_illegal, dec_is_md;

   ctrl_decode_comb #(
      .INSN_W   (INSN_W),
      .OPCODE_W (OPCODE_W),
      .REG_W    (REG_W),
      .IMM_W    (IMM_W),
      .CTRL_W   (CTRL_W)
   ) u_decode (
      .insn    (in_insn),
      .ctrl    (dec_ctrl),
      .aluop   (dec_aluop),
      .rd      (dec_rd),
      .rs      (dec_rs),
      .rt      (dec_rt),
      .imm     (dec_imm),
      .illegal (dec_illegal),
      .is_md   (dec_is_md)
   );

   logic accept;     // instruction taken this cycle
   logic md_go;      // accepted instruction goes to the mult/div unit
   logic md_fire;    // waiting mult/div result arrives
   logic in_wait;    // sequencer is in MD_WAIT
   logic out_valid_next;

`ifdef DECODE_MULTDIV_EN
   state_t state, state_next;

   assign in_wait = (state == ST_MD_WAIT);
   assign md_go   = accept && dec_is_md;
   assign md_fire = in_wait && md_done;

   always_comb begin
      state_next = state;
      if (flush)        state_next = ST_IDLE;
      else if (md_go)   state_next = ST_MD_WAIT;
      else if (md_fire) state_next = ST_IDLE;
   end

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end
`else
   logic unused_md;

   assign in_wait   = 1'b0;
   assign md_go     = 1'b0;
   assign md_fire   = 1'b0;
   assign unused_md = md_done ^ dec_is_md;
`endif

   assign in_ready = !flush && !in_wait && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_next = out_valid;
      if (flush)          out_valid_next = 1'b0;
      else if (accept)    out_valid_next = !md_go;  // mul/div stays hidden until md_done
      else if (md_fire)   out_valid_next = 1'b1;
      else if (out_ready) out_valid_next = 1'b0;
   end

   // Fields load on every accept; a mul/div parks its fields here while out_valid is low.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         md_start  <= 1'b0;
         illegal   <= 1'b0;
         out_ctrl  <= '0;
         out_aluop <= '0;
         out_rd    <= '0;
         out_rs    <= '0;
         out_rt    <= '0;
         out_imm   <= '0;
      end else begin
         out_valid <= out_valid_next;
         md_start  <= md_go;
         if (accept) begin
            illegal   <= dec_illegal;
            out_ctrl  <= dec_ctrl;
            out_aluop <= dec_aluop;
            out_rd    <= dec_rd;
            out_rs    <= dec_rs;
            out_rt    <= dec_rt;
            out_imm   <= dec_imm;
         end
      end
   end

endmodule

// File: tb/tb_ctrl_decode_stage.sv
module tb_ctrl_decode_stage;

`ifdef DECODE_MULTDIV_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_insn = '0;
   logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, md_done = 1'b0;
   logic        in_ready, out_valid, md_start, illegal;
   logic [11:0] out_ctrl;
   logic [4:0]  out_aluop, out_rd, out_rs, out_rt;
   logic [31:0] out_imm;

   always #5 clock = ~clock;

   ctrl_decode_stage dut (
      .clock     (clock),
      .reset     (reset),
      .in_insn   (in_insn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_ctrl  (out_ctrl),
      .out_aluop (out_aluop),
      .out_rd    (out_rd),
      .out_rs    (out_rs),
      .out_rt    (out_rt),
      .out_imm   (out_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .md_start  (md_start),
      .md_done   (md_done),
      .illegal   (illegal)
   );

   typedef struct packed {
      logic [11:0] ctrl;
      logic [4:0]  aluop, rd, rs, rt;
      logic [31:0] imm;
      logic        ill;
      logic        md;
   } dec_t;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic m_valid = 1'b0, m_wait = 1'b0, m_start = 1'b0, m_fresh = 1'b1;
   dec_t m_f = '0;
   int   md_pulses = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Control word built from named bit positions, straight from the opcode table.
   function automatic dec_t ref_dec(input logic [31:0] w);
      dec_t d;
      logic [11:0] c;
      logic [4:0]  op;
      op = w[31:27];
      d = '0;
      c = '0;
      d.rd = w[26:22];
      d.rs = w[21:17];
      d.rt = w[16:12];
      d.imm = {{15{w[16]}}, w[16:0]};
      case (op)
         5'd0:  begin c = 12'b0000_0000_0100; d.aluop = w[6:2];
                      d.md = (w[6:2] == 5'd6) || (w[6:2] == 5'd7); end
         5'd1:  c = 12'b0010_0000_0000;
         5'd2:  c = 12'b1000_0000_0010;
         5'd3:  c = 12'b0011_0000_0100;
         5'd4:  c = 12'b0000_1000_0010;
         5'd5:  c = 12'b0000_0001_0100;
         5'd6:  c = 12'b0100_0000_0010;
         5'd7:  c = 12'b0000_0001_1010;
         5'd8:  c = 12'b0000_0001_0101;
         5'd21: c = 12'b0000_0010_0100;
         5'd22: c = 12'b0000_0100_0000;
         default: d.ill = 1'b1;
      endcase
      d.ctrl = c;
      return d;
   endfunction

   function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt,
                                      input logic [16:0] imm);
      logic [31:0] w;
      w = {op[4:0], rd[4:0], rs[4:0], 17'h0};
      w[16:12] = rt[4:0];
      w[16:0]  = w[16:0] | imm;
      return w;
   endfunction

   function automatic logic [31:0] mkr(input int rd, input int rs, input int rt, input int aluop);
      logic [31:0] w;
      w = {5'd0, rd[4:0], rs[4:0], rt[4:0], 5'd0, aluop[4:0], 2'b00};
      return w;
   endfunction

   // One clock cycle: drive, check in_ready, advance model, check registered outputs.
   task automatic cycle(input logic v, input logic [31:0] insn, input logic ordy,
                        input logic fl, input logic done, input logic rst);
      logic exp_rdy, acc;
      dec_t d;
      reset = rst; in_valid = v; in_insn = insn; out_ready = ordy; flush = fl; md_done = done;
      #1;
      exp_rdy = !fl && !m_wait && (!m_valid || ordy);
      if (!rst) chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      acc = v && exp_rdy;
      d = ref_dec(insn);
      @(posedge clock);
      if (rst) begin
         m_valid = 0; m_wait = 0; m_start = 0; m_fresh = 1; m_f = '0;
      end else if (fl) begin
         m_valid = 0; m_wait = 0; m_start = 0;
      end else if (acc) begin
         m_f = d; m_fresh = 0;
         if (MD_EN && d.md) begin m_wait = 1; m_valid = 0; m_start = 1; end
         else begin m_valid = 1; m_start = 0; end
      end else begin
         m_start = 0;
         if (m_wait && done) begin m_valid = 1; m_wait = 0; end
         else if (ordy) m_valid = 0;
      end
      @(negedge clock);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("md_start", {31'd0, md_start}, {31'd0, m_start});
      if (md_start) md_pulses++;
      if (m_valid || m_fresh) begin
         chk("out_ctrl", {20'd0, out_ctrl}, {20'd0, m_f.ctrl});
         chk("out_aluop", {27'd0, out_aluop}, {27'd0, m_f.aluop});
         chk("out_rd", {27'd0, out_rd}, {27'd0, m_f.rd});
         chk("out_rs", {27'd0, out_rs}, {27'd0, m_f.rs});
         chk("out_rt", {27'd0, out_rt}, {27'd0, m_f.rt});
         chk("out_imm", out_imm, m_f.imm);
         chk("illegal", {31'd0, illegal}, {31'd0, m_f.ill});
      end
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 32'h0, ordy, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] rand_insn();
      int ops[14] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22, 31};
      int op;
      logic [31:0] w;
      op = ops[$urandom_range(0, 13)];
      if ($urandom_range(0, 9) == 0) op = $urandom_range(0, 31);
      w = $urandom;
      w[31:27] = op[4:0];
      if (op == 0 && $urandom_range(0, 1) == 1) w[6:2] = 5'd6 + 5'($urandom_range(0, 1));
      return w;
   endfunction

   logic [31:0] lw_i, addi_i, sw_i, mul_i, div_i, bad_i;

   initial begin
      lw_i   = mk(8, 3, 4, 0, 17'h1FFFF);
      addi_i = mk(5, 7, 2, 0, 17'h00010);
      sw_i   = mk(7, 9, 1, 0, 17'h00004);
      mul_i  = mkr(10, 11, 12, 6);
      div_i  = mkr(13, 14, 15, 7);
      bad_i  = mk(31, 1, 2, 3, 17'h00123);

      @(negedge clock);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      chk("reset_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_ctrl", {20'd0, out_ctrl}, 32'd0);

      // back-to-back lw, addi
      cycle(1, lw_i, 1, 0, 0, 0);
      chk("lw_ctrl", {20'd0, out_ctrl}, 32'h015);
      chk("lw_imm", out_imm, 32'hFFFF_FFFF);
      cycle(1, addi_i, 1, 0, 0, 0);
      chk("addi_ctrl", {20'd0, out_ctrl}, 32'h014);
      idle(1);

      // stall with sw held for 3 cycles
      cycle(1, sw_i, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(1, addi_i, 0, 0, 0, 0);
         chk("stall_ctrl", {20'd0, out_ctrl}, 32'h01A);
      end
      cycle(1, addi_i, 1, 0, 0, 0);
      chk("after_stall_ctrl", {20'd0, out_ctrl}, 32'h014);
      idle(1);

      // mul with md_done 5 cycles after md_start
      md_pulses = 0;
      cycle(1, mul_i, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) idle(0);
      cycle(0, 0, 0, 0, 1, 0);
      idle(0);
      chk("mul_valid", {31'd0, out_valid}, 32'd1);
      chk("mul_ctrl", {20'd0, out_ctrl}, 32'h004);
      chk("mul_pulses", md_pulses, MD_EN ? 32'd1 : 32'd0);
      idle(1);

      // flush during wait, then late md_done
      cycle(1, div_i, 1, 0, 0, 0);
      cycle(0, 0, 1, 1, 0, 0);
      cycle(0, 0, 1, 0, 1, 0);
      idle(0);
      chk("flush_valid", {31'd0, out_valid}, 32'd0);

      // illegal opcode then legal
      cycle(1, bad_i, 1, 0, 0, 0);
      chk("bad_ctrl", {20'd0, out_ctrl}, 32'd0);
      chk("bad_illegal", {31'd0, illegal}, 32'd1);
      chk("bad_valid", {31'd0, out_valid}, 32'd1);
      cycle(1, addi_i, 1, 0, 0, 0);
      chk("clear_illegal", {31'd0, illegal}, 32'd0);
      idle(1);

      // reset in the middle of a mult/div wait
      cycle(1, mul_i, 1, 0, 0, 0);
      idle(0);
      cycle(0, 0, 0, 0, 0, 1);
      reset = 0; in_valid = 0; flush = 0; out_ready = 0; md_done = 0;
      #1;
      chk("rst_wait_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_wait_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_wait_start", {31'd0, md_start}, 32'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 3) != 0), rand_insn(), ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 14) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 199) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
